// File: rtl/div_16b_pkg.sv
// div_16b_pkg: shared definitions for the sequential restoring divider.
//   DIV_WIDTH_DEFAULT  default operand/result width
//   ST_IDLE/ST_CALC/ST_DONE  state encodings, wrapped by the state_t enum
package div_16b_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/div_16b_sub_nb.sv
// sub_nb: N-bit ripple subtractor built from full-adder cells as a + ~b + 1.
// Ports:
//   a, b    in   N  minuend, subtrahend
//   diff    out  N  a - b (modulo 2^N)
//   borrow  out  1  high when b > a
module sub_nb #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign diff[i]    = a[i] ^ ~b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & ~b[i]) | (a[i] & carry[i]) | (~b[i] & carry[i]);
  end

  // No carry out of a + ~b + 1 means the true difference went negative.
  assign borrow = ~carry[N];

endmodule

// File: rtl/div_16b_seq.sv
// div_16b_seq: sequential unsigned restoring divider, one quotient bit per clock,
// valid/ready handshake on operands and result.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake; a (dividend) and b (divisor) sampled at acceptance
//   out_valid/out_ready result handshake; out_valid held until taken
//   quot, rem           quotient and remainder, held until the next result is loaded
//   div_by_zero         b was zero for the current result
// Build option: DIV16_ZERO_BYPASS_EN -- a zero divisor skips the iteration and
// goes straight to DONE with the same result values.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one restoring iteration per cycle, WIDTH cycles
// DONE  | first cycle loads the result registers, then holds out_valid until taken
module div_16b_seq
  import div_16b_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_reg, r_reg, d_reg;
  logic [CW-1:0]    count;
  logic             dz_reg;
  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   t;
  logic             borrow;
  logic             unused_t_msb;

  assign accept    = in_valid && (state == S_IDLE);
  assign last_iter = (count == CW'(WIDTH - 1));

  sub_nb #(.N(WIDTH + 1)) u_sub (
    .a      ({r_reg, q_reg[WIDTH-1]}),
    .b      ({1'b0, d_reg}),
    .diff   (t),
    .borrow (borrow)
  );

  // When there is no borrow the partial remainder fits in WIDTH bits, so the
  // top difference bit is always zero where it would be used.
  assign unused_t_msb = t[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
`ifdef DIV16_ZERO_BYPASS_EN
          state_nx = (b == '0) ? S_DONE : S_CALC;
`else
          state_nx = S_CALC;
`endif
        end
      end
      S_CALC:  if (last_iter) state_nx = S_DONE;
      S_DONE:  if (out_valid && out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      dz_reg      <= 1'b0;
      out_valid   <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            d_reg  <= b;
            count  <= '0;
            dz_reg <= (b == '0);
`ifdef DIV16_ZERO_BYPASS_EN
            // Preload what the full iteration would have produced for b == 0.
            if (b == '0) begin
              q_reg <= '1;
              r_reg <= a;
            end else begin
              q_reg <= a;
              r_reg <= '0;
            end
`else
            q_reg <= a;
            r_reg <= '0;
`endif
          end
        end
        S_CALC: begin
          if (!borrow) begin
            r_reg <= t[WIDTH-1:0];
            q_reg <= {q_reg[WIDTH-2:0], 1'b1};
          end else begin
            r_reg <= {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
            q_reg <= {q_reg[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
        end
        S_DONE: begin
          if (!out_valid) begin
            quot        <= q_reg;
            rem         <= r_reg;
            div_by_zero <= dz_reg;
            out_valid   <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_16b_seq.sv
module tb_div_16b_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  quot, rem;
  logic          div_by_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_16b_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic, with the zero-divisor result defined as all ones / a.
  task automatic model(input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] q, output logic [15:0] r, output logic dz);
    if (bv == 0) begin
      q = 16'hFFFF; r = av; dz = 1'b1;
    end else begin
      q = av / bv; r = av % bv; dz = 1'b0;
    end
  endtask

  function automatic int exp_lat(input logic [15:0] bv);
`ifdef DIV16_ZERO_BYPASS_EN
    return (bv == 0) ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int hold,
                        input string nm);
    logic [15:0] eq, er;
    logic        edz;
    int          n;
    model(av, bv, eq, er, edz);
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk({nm, " accept_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk({nm, " latency"}, n, exp_lat(bv));
    chk({nm, " quot"}, quot, eq);
    chk({nm, " rem"}, rem, er);
    chk({nm, " dz"}, div_by_zero, edz);
    chk({nm, " in_ready_busy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " held_valid_ready"}, {out_valid, in_ready}, 2'b10);
      chk({nm, " held_result"}, {quot, rem}, {eq, er});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " taken"}, {out_valid, in_ready}, 2'b01);
    chk({nm, " result_kept"}, {quot, rem}, {eq, er});
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    logic saw_valid;
    logic [15:0] rb;

    vecs[0] = '{16'd100,    16'd7,      16'd14,     16'd2,  1'b0, 0};
    vecs[1] = '{16'hFFFF,   16'd1,      16'hFFFF,   16'd0,  1'b0, 1};
    vecs[2] = '{16'd3,      16'd10,     16'd0,      16'd3,  1'b0, 0};
    vecs[3] = '{16'd5,      16'd0,      16'hFFFF,   16'd5,  1'b1, 2};
    vecs[4] = '{16'd1000,   16'd33,     16'd30,     16'd10, 1'b0, 5};
    vecs[5] = '{16'hFFFF,   16'hFFFF,   16'd1,      16'd0,  1'b0, 0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {in_ready, out_valid, div_by_zero, quot, rem}, {3'b100, 32'd0});
    rst = 1'b0;

    // Table vectors: expectations are the literal values from the datasheet cases.
    for (int i = 0; i < 6; i++) begin
      logic [15:0] mq, mr;
      logic mdz;
      model(vecs[i].a, vecs[i].b, mq, mr, mdz);
      chk($sformatf("vec%0d model", i), {mq, mr}, {vecs[i].q, vecs[i].r});
      run_op(vecs[i].a, vecs[i].b, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Reset during CALC aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; a = 16'd1234; b = 16'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abort reset outputs", {in_ready, out_valid, div_by_zero, quot, rem}, {3'b100, 32'd0});
    @(negedge clk); rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort no out_valid", saw_valid, 0);
    run_op(16'd81, 16'd9, 0, "after_abort");

    // Back-to-back with in_valid held and operands changing after acceptance.
    @(negedge clk);
    in_valid = 1'b1; a = 16'd200; b = 16'd7; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 16'd999;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("b2b first latency", n, W + 1);
    chk("b2b first result", {quot, rem}, {16'd28, 16'd4});
    @(posedge clk); #1;
    chk("b2b bubble", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    chk("b2b second accepted", in_ready, 0);
    a = 16'd5; b = 16'd3;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("b2b second latency", n, W + 1);
    chk("b2b second result", {quot, rem, 15'd0, div_by_zero}, {16'd142, 16'd5, 16'd0});
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b second taken", out_valid, 0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)      rb = 16'd0;
      else if ($urandom_range(0, 1) == 1) rb = 16'($urandom_range(1, 300));
      else                                rb = 16'($urandom);
      run_op(16'($urandom), rb, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
